// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its operand forwarding.
package id_ex_stage_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_ZERO,
      FWD_MEM,
      FWD_WB,
      FWD_RF
   } fwd_sel_e;

   // True when a producer writing rd creates a dependency for a used, non-x0 source rs.
   function automatic logic raw_hit(input logic                  used,
                                    input logic [REG_ADDR_W-1:0] rs,
                                    input logic                  wren,
                                    input logic [REG_ADDR_W-1:0] rd);
      return used & (rs != '0) & wren & (rd == rs);
   endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: x0, MEM-stage ALU result, WB result, or register file.
module operand_fwd_mux
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned Width = XLEN
) (
   input  logic [REG_ADDR_W-1:0] rs_addr_i,
   input  logic [Width-1:0]      rf_data_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
   input  logic                  mem_rd_wren_i,
   input  logic                  mem_is_load_i,
   input  logic [Width-1:0]      mem_rd_data_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
   input  logic                  wb_rd_wren_i,
   input  logic [Width-1:0]      wb_rd_data_i,
   output logic [Width-1:0]      operand_o
);

   fwd_sel_e sel;

   // A load in MEM has no data yet; the hazard logic stalls instead of forwarding it.
   always_comb begin
      sel = FWD_RF;
      if (rs_addr_i == '0) begin
         sel = FWD_ZERO;
      end else if (mem_rd_wren_i && !mem_is_load_i && (mem_rd_addr_i == rs_addr_i)) begin
         sel = FWD_MEM;
      end else if (wb_rd_wren_i && (wb_rd_addr_i == rs_addr_i)) begin
         sel = FWD_WB;
      end
   end

   always_comb begin
      operand_o = rf_data_i;
      unique case (sel)
         FWD_ZERO: operand_o = '0;
         FWD_MEM:  operand_o = mem_rd_data_i;
         FWD_WB:   operand_o = wb_rd_data_i;
         FWD_RF:   operand_o = rf_data_i;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, RAW/load-use stall and flush.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CTRLW = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_id_valid,
   output logic                  o_id_ready,
   input  logic [XLEN-1:0]       i_id_pc,
   input  logic [CTRLW-1:0]      i_id_ctrl,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr,
   input  logic                  i_rs1_used,
   input  logic                  i_rs2_used,
   input  logic [REG_ADDR_W-1:0] i_rd_addr,
   input  logic                  i_rd_wren,
   input  logic                  i_id_is_load,
   output logic [REG_ADDR_W-1:0] o_rf_rs1_addr,
   output logic [REG_ADDR_W-1:0] o_rf_rs2_addr,
   input  logic [XLEN-1:0]       i_rf_rs1_data,
   input  logic [XLEN-1:0]       i_rf_rs2_data,
   input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
   input  logic                  i_mem_rd_wren,
   input  logic                  i_mem_is_load,
   input  logic [XLEN-1:0]       i_mem_rd_data,
   input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
   input  logic                  i_wb_rd_wren,
   input  logic [XLEN-1:0]       i_wb_rd_data,
   output logic                  o_ex_valid,
   input  logic                  i_ex_ready,
   output logic [XLEN-1:0]       o_ex_pc,
   output logic [CTRLW-1:0]      o_ex_ctrl,
   output logic [XLEN-1:0]       o_ex_rs1_data,
   output logic [XLEN-1:0]       o_ex_rs2_data,
   output logic [REG_ADDR_W-1:0] o_ex_rd_addr,
   output logic                  o_ex_rd_wren,
   output logic                  o_ex_is_load,
   input  logic                  i_flush,
   output logic                  o_hazard_stall
);

   logic                  ex_valid_q, ex_valid_d;
   logic [XLEN-1:0]       ex_pc_q, ex_pc_d;
   logic [CTRLW-1:0]      ex_ctrl_q, ex_ctrl_d;
   logic [XLEN-1:0]       ex_rs1_q, ex_rs1_d;
   logic [XLEN-1:0]       ex_rs2_q, ex_rs2_d;
   logic [REG_ADDR_W-1:0] ex_rd_addr_q, ex_rd_addr_d;
   logic                  ex_rd_wren_q, ex_rd_wren_d;
   logic                  ex_is_load_q, ex_is_load_d;

   logic [XLEN-1:0] rs1_fwd, rs2_fwd;
   logic            hazard, ex_free, accept;

   assign o_rf_rs1_addr = i_rs1_addr;
   assign o_rf_rs2_addr = i_rs2_addr;

   operand_fwd_mux #(.Width(XLEN)) u_fwd_rs1 (
      .rs_addr_i     (i_rs1_addr),
      .rf_data_i     (i_rf_rs1_data),
      .mem_rd_addr_i (i_mem_rd_addr),
      .mem_rd_wren_i (i_mem_rd_wren),
      .mem_is_load_i (i_mem_is_load),
      .mem_rd_data_i (i_mem_rd_data),
      .wb_rd_addr_i  (i_wb_rd_addr),
      .wb_rd_wren_i  (i_wb_rd_wren),
      .wb_rd_data_i  (i_wb_rd_data),
      .operand_o     (rs1_fwd)
   );

   operand_fwd_mux #(.Width(XLEN)) u_fwd_rs2 (
      .rs_addr_i     (i_rs2_addr),
      .rf_data_i     (i_rf_rs2_data),
      .mem_rd_addr_i (i_mem_rd_addr),
      .mem_rd_wren_i (i_mem_rd_wren),
      .mem_is_load_i (i_mem_is_load),
      .mem_rd_data_i (i_mem_rd_data),
      .wb_rd_addr_i  (i_wb_rd_addr),
      .wb_rd_wren_i  (i_wb_rd_wren),
      .wb_rd_data_i  (i_wb_rd_data),
      .operand_o     (rs2_fwd)
   );

   // EX producer stalls one cycle; a load stalls again while it sits in MEM.
   always_comb begin
      hazard = raw_hit(i_rs1_used, i_rs1_addr, ex_valid_q & ex_rd_wren_q, ex_rd_addr_q)
             | raw_hit(i_rs2_used, i_rs2_addr, ex_valid_q & ex_rd_wren_q, ex_rd_addr_q)
             | raw_hit(i_rs1_used, i_rs1_addr, i_mem_rd_wren & i_mem_is_load, i_mem_rd_addr)
             | raw_hit(i_rs2_used, i_rs2_addr, i_mem_rd_wren & i_mem_is_load, i_mem_rd_addr);
   end

   assign ex_free        = !ex_valid_q || i_ex_ready;
   assign o_id_ready     = !hazard && !i_flush && ex_free;
   assign accept         = i_id_valid && o_id_ready;
   assign o_hazard_stall = i_id_valid && hazard;

   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_pc_d      = ex_pc_q;
      ex_ctrl_d    = ex_ctrl_q;
      ex_rs1_d     = ex_rs1_q;
      ex_rs2_d     = ex_rs2_q;
      ex_rd_addr_d = ex_rd_addr_q;
      ex_rd_wren_d = ex_rd_wren_q;
      ex_is_load_d = ex_is_load_q;
      if (i_flush || (ex_free && !accept)) begin
         ex_valid_d   = 1'b0;
         ex_rd_wren_d = 1'b0;
         ex_is_load_d = 1'b0;
      end else if (accept) begin
         ex_valid_d   = 1'b1;
         ex_pc_d      = i_id_pc;
         ex_ctrl_d    = i_id_ctrl;
         ex_rs1_d     = rs1_fwd;
         ex_rs2_d     = rs2_fwd;
         ex_rd_addr_d = i_rd_addr;
         ex_rd_wren_d = i_rd_wren;
         ex_is_load_d = i_id_is_load;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ex_valid_q   <= 1'b0;
         ex_pc_q      <= '0;
         ex_ctrl_q    <= '0;
         ex_rs1_q     <= '0;
         ex_rs2_q     <= '0;
         ex_rd_addr_q <= '0;
         ex_rd_wren_q <= 1'b0;
         ex_is_load_q <= 1'b0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_pc_q      <= ex_pc_d;
         ex_ctrl_q    <= ex_ctrl_d;
         ex_rs1_q     <= ex_rs1_d;
         ex_rs2_q     <= ex_rs2_d;
         ex_rd_addr_q <= ex_rd_addr_d;
         ex_rd_wren_q <= ex_rd_wren_d;
         ex_is_load_q <= ex_is_load_d;
      end
   end

   assign o_ex_valid    = ex_valid_q;
   assign o_ex_pc       = ex_pc_q;
   assign o_ex_ctrl     = ex_ctrl_q;
   assign o_ex_rs1_data = ex_rs1_q;
   assign o_ex_rs2_data = ex_rs2_q;
   assign o_ex_rd_addr  = ex_rd_addr_q;
   assign o_ex_rd_wren  = ex_rd_wren_q;
   assign o_ex_is_load  = ex_is_load_q;

endmodule
